// File: rtl/sound_event_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sound_pkg
// Description : Shared types and constants for the sound event scheduler:
//               sound_type codes, FSM state encodings, duration width and
//               the fixed arbitration priority rank.
// Revision    : 1.0 - initial release
// ============================================================================
package sound_pkg;

  // Width of the duration down-counter
  localparam int DUR_W = 4;

  // Codes presented to the sound player
  typedef enum logic [1:0] {
    SND_PUSH    = 2'd0,
    SND_WINRND  = 2'd1,
    SND_SPEED   = 2'd2,
    SND_WINGAME = 2'd3
  } sound_t;

  // Scheduler states; 2'd3 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Arbitration rank (higher wins): wingame > winrnd > speed > push.
  // Differs from the code order because winrnd outranks speed.
  function automatic logic [1:0] prio(sound_t s);
    logic [1:0] r;
    r = 2'd0;
    case (s)
      SND_WINGAME: r = 2'd3;
      SND_WINRND:  r = 2'd2;
      SND_SPEED:   r = 2'd1;
      default:     r = 2'd0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sound_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : sound_event_scheduler_if
// Description : Event request / sound player bus between the game logic
//               (master) and the sound event scheduler (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sound_event_scheduler_if;
  import sound_pkg::*;

  logic   tick;
  logic   req_push;
  logic   req_winrnd;
  logic   req_wingame;
  logic   req_speed;
  sound_t sound_type;
  logic   notshutdown;
  logic   gain;
  logic   busy;

  modport master (
    output tick, req_push, req_winrnd, req_wingame, req_speed,
    input  sound_type, notshutdown, gain, busy
  );

  modport slave (
    input  tick, req_push, req_winrnd, req_wingame, req_speed,
    output sound_type, notshutdown, gain, busy
  );

endinterface
`default_nettype wire

// File: rtl/sound_event_scheduler_timer.sv
`default_nettype none
// ============================================================================
// Module      : sound_duration_timer
// Description : Loadable tick-driven down-counter measuring sound length.
//               done flags the last tick period (count == 1).
// Revision    : 1.0 - initial release
// ============================================================================
module sound_duration_timer
  import sound_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [DUR_W-1:0] load_val,
  input  wire logic             tick,
  output logic      [DUR_W-1:0] count,
  output logic                  done
);

  logic [DUR_W-1:0] r_count;

  // Load takes precedence; otherwise count down once per tick, floor at 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign done  = (r_count == DUR_W'(1));

endmodule
`default_nettype wire

// File: rtl/sound_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sound_event_scheduler
// Description : Latches game sound events, arbitrates them by fixed priority
//               and sequences IDLE -> PLAY -> GAP so that sounds are always
//               separated by at least one tick period of silence.
//               Optional macro SOUND_PREEMPT_EN: a strictly higher-priority
//               request aborts the current sound and regrants directly.
// Revision    : 1.0 - initial release
// ============================================================================
module sound_event_scheduler
  import sound_pkg::*;
#(
  parameter int DUR_PUSH    = 2,
  parameter int DUR_WINRND  = 4,
  parameter int DUR_WINGAME = 8
) (
  input wire logic          clk,
  input wire logic          rst,
  sound_event_scheduler_if.slave bus
);

  localparam logic [DUR_W-1:0] c_dur_push    = DUR_W'(DUR_PUSH);
  localparam logic [DUR_W-1:0] c_dur_winrnd  = DUR_W'(DUR_WINRND);
  localparam logic [DUR_W-1:0] c_dur_wingame = DUR_W'(DUR_WINGAME);

  state_t           r_state;
  sound_t           r_sound_type;
  logic             r_notshutdown;
  logic             r_busy;
  logic             r_pend_push;
  logic             r_pend_winrnd;
  logic             r_pend_wingame;

  logic             w_any;
  sound_t           w_grant_type;
  logic [DUR_W-1:0] w_grant_dur;
  logic             w_preempt;
  logic             w_do_grant;
  logic             w_play_end;
  logic             w_done;
  logic [DUR_W-1:0] w_count;

  assign w_any = r_pend_wingame | r_pend_winrnd | bus.req_speed | r_pend_push;

  // Fixed-priority arbiter; speed is taken live, the others from pending bits
  always_comb begin
    w_grant_type = SND_PUSH;
    w_grant_dur  = c_dur_push;
    if (r_pend_wingame) begin
      w_grant_type = SND_WINGAME;
      w_grant_dur  = c_dur_wingame;
    end else if (r_pend_winrnd) begin
      w_grant_type = SND_WINRND;
      w_grant_dur  = c_dur_winrnd;
    end else if (bus.req_speed) begin
      w_grant_type = SND_SPEED;
      w_grant_dur  = '0;
    end
  end

`ifdef SOUND_PREEMPT_EN
  assign w_preempt = (r_state == ST_PLAY) && w_any &&
                     (prio(w_grant_type) > prio(r_sound_type));
`else
  assign w_preempt = 1'b0;
`endif

  assign w_do_grant = ((r_state == ST_IDLE) && w_any) || w_preempt;

  // Speed sound lasts while the level is high; timed sounds end on the last tick
  assign w_play_end = bus.tick &&
                      ((r_sound_type == SND_SPEED) ? !bus.req_speed : w_done);

  // Sticky pending bits; a new pulse in the grant cycle wins over the clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend_push    <= 1'b0;
      r_pend_winrnd  <= 1'b0;
      r_pend_wingame <= 1'b0;
    end else begin
      r_pend_push    <= bus.req_push |
                        (r_pend_push & ~(w_do_grant && (w_grant_type == SND_PUSH)));
      r_pend_winrnd  <= bus.req_winrnd |
                        (r_pend_winrnd & ~(w_do_grant && (w_grant_type == SND_WINRND)));
      r_pend_wingame <= bus.req_wingame |
                        (r_pend_wingame & ~(w_do_grant && (w_grant_type == SND_WINGAME)));
    end
  end

  // Scheduler FSM with registered player/amplifier outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_sound_type  <= SND_PUSH;
      r_notshutdown <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_do_grant) begin
            r_state       <= ST_PLAY;
            r_sound_type  <= w_grant_type;
            r_notshutdown <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_do_grant) begin
            r_sound_type  <= w_grant_type;
          end else if (w_play_end) begin
            r_state       <= ST_GAP;
            r_notshutdown <= 1'b0;
          end
        end
        ST_GAP: begin
          if (bus.tick) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_notshutdown <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  sound_duration_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_do_grant),
    .load_val (w_grant_dur),
    .tick     (bus.tick),
    .count    (w_count),
    .done     (w_done)
  );

  assign bus.sound_type  = r_sound_type;
  assign bus.notshutdown = r_notshutdown;
  assign bus.gain        = 1'b1;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sound_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sound_event_scheduler
// Description : Directed self-checking bench for sound_event_scheduler with
//               default durations and a tick every 4 clock cycles.
//               Honours SOUND_PREEMPT_EN for the preemption scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_event_scheduler;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   cyc_n;

  sound_event_scheduler_if bus ();

  sound_event_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded loop is somehow bypassed
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; tick is high before every 4th edge
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    bus.tick = ((cyc_n % 4) == 0);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: bus.req_push    = 1'b1;
      1: bus.req_winrnd  = 1'b1;
      default: bus.req_wingame = 1'b1;
    endcase
    cyc();
    bus.req_push    = 1'b0;
    bus.req_winrnd  = 1'b0;
    bus.req_wingame = 1'b0;
  endtask

  task automatic wait_play(input string tag);
    int n;
    n = 0;
    while (!bus.notshutdown && n < 200) begin
      cyc();
      n++;
    end
    chk(tag, int'(bus.notshutdown), 1);
  endtask

  task automatic wait_play_end(input string tag, input int exp_type);
    int n;
    n = 0;
    while (bus.notshutdown && n < 200) begin
      cyc();
      n++;
    end
    chk({tag, "_gap"}, int'(bus.busy), 1);
    chk({tag, "_type"}, int'(bus.sound_type), exp_type);
  endtask

  // Follows one sound from (or before) its start through its gap
  task automatic observe_sound(input string tag, input int exp_type, input int exp_ticks);
    int n;
    int play_ticks;
    int gap_ticks;
    wait_play({tag, "_start"});
    chk({tag, "_type"}, int'(bus.sound_type), exp_type);
    play_ticks = 0;
    n = 0;
    while (bus.notshutdown && n < 400) begin
      if (bus.tick) play_ticks++;
      cyc();
      n++;
    end
    chk({tag, "_play_ticks"}, play_ticks, exp_ticks);
    chk({tag, "_gap_busy"}, int'(bus.busy), 1);
    gap_ticks = 0;
    n = 0;
    while (bus.busy && n < 100) begin
      if (bus.tick) gap_ticks++;
      cyc();
      n++;
    end
    chk({tag, "_gap_ticks"}, gap_ticks, 1);
    chk({tag, "_idle"}, int'(bus.busy), 0);
  endtask

  // Expects no activity for n cycles
  task automatic idle_watch(input string tag, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (bus.busy) act++;
    end
    chk(tag, act, 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc_n    = 0;
    rst             = 1'b0;
    bus.tick        = 1'b0;
    bus.req_push    = 1'b0;
    bus.req_winrnd  = 1'b0;
    bus.req_wingame = 1'b0;
    bus.req_speed   = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_type", int'(bus.sound_type), 0);
    chk("rst_notshutdown", int'(bus.notshutdown), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_gain", int'(bus.gain), 1);
    rst = 1'b1;
    cyc();

    // Single push: pending after the pulse, PLAY one edge later
    pulse(0);
    chk("push_pending_only", int'(bus.busy), 0);
    cyc();
    chk("push_latency", int'(bus.notshutdown), 1);
    observe_sound("push", 0, 2);
    chk("push_gain", int'(bus.gain), 1);
    idle_watch("push_after", 12);

    // Simultaneous pulses: wingame first, then push
    bus.req_push    = 1'b1;
    bus.req_wingame = 1'b1;
    cyc();
    bus.req_push    = 1'b0;
    bus.req_wingame = 1'b0;
    observe_sound("simul_wingame", 3, 8);
    observe_sound("simul_push", 0, 2);
    idle_watch("simul_after", 12);

    // Speed round held for 20 cycles
    bus.req_speed = 1'b1;
    cyc();
    chk("speed_start", int'(bus.notshutdown), 1);
    chk("speed_type", int'(bus.sound_type), 2);
    for (int i = 0; i < 19; i++) cyc();
    chk("speed_held", int'(bus.notshutdown), 1);
    bus.req_speed = 1'b0;
    begin : speed_drop
      int n;
      int early;
      logic t;
      n = 0;
      early = 0;
      t = 1'b0;
      while (n < 10) begin
        t = bus.tick;
        cyc();
        n++;
        if (t) break;
        if (!bus.notshutdown) early++;
      end
      chk("speed_no_early_end", early, 0);
      chk("speed_gap_on_tick", int'(bus.notshutdown), 0);
      chk("speed_gap_busy", int'(bus.busy), 1);
    end
    for (int i = 0; i < 6; i++) cyc();
    chk("speed_idle", int'(bus.busy), 0);
    chk("speed_type_hold", int'(bus.sound_type), 2);

    // Three push pulses collapse into one push during a winrnd sound
    pulse(1);
    wait_play("winrnd_start");
    chk("winrnd_type", int'(bus.sound_type), 1);
    for (int i = 0; i < 3; i++) begin
      pulse(0);
      cyc();
    end
    wait_play_end("winrnd", 1);
    observe_sound("collapse_push", 0, 2);
    idle_watch("collapse_single", 30);

    // Push re-armed in its own grant cycle plays twice
    bus.req_push = 1'b1;
    cyc();
    cyc();
    bus.req_push = 1'b0;
    observe_sound("rearm_push1", 0, 2);
    observe_sound("rearm_push2", 0, 2);
    idle_watch("rearm_after", 20);

    // Reset mid wingame with push pending
    pulse(3);
    wait_play("rstmid_start");
    pulse(0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("rstmid_busy", int'(bus.busy), 0);
    chk("rstmid_notshutdown", int'(bus.notshutdown), 0);
    chk("rstmid_type", int'(bus.sound_type), 0);
    idle_watch("rstmid_no_push", 40);

    // Wingame request while push is playing
    pulse(0);
    wait_play("pre_push_start");
    chk("pre_push_type", int'(bus.sound_type), 0);
    pulse(3);
    cyc();
`ifdef SOUND_PREEMPT_EN
    chk("pre_type", int'(bus.sound_type), 3);
    chk("pre_notshutdown", int'(bus.notshutdown), 1);
    chk("pre_counter", int'(dut.u_timer.count), 8);
    observe_sound("pre_wingame", 3, 8);
`else
    chk("nopre_type", int'(bus.sound_type), 0);
    chk("nopre_notshutdown", int'(bus.notshutdown), 1);
    wait_play_end("nopre_push", 0);
    observe_sound("nopre_wingame", 3, 8);
`endif
    idle_watch("pre_after", 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
